// File: rtl/tape_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tape_timing_pkg
// Description : Default tick/pulse-count constants and FSM state encoding
//               for the cassette tape pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package tape_timing_pkg;

    // Default pulse half-period lengths in clk ticks
    localparam int C_PILOT_TICKS = 2168;
    localparam int C_SYNC1_TICKS = 667;
    localparam int C_SYNC2_TICKS = 735;
    localparam int C_BIT0_TICKS  = 855;
    localparam int C_BIT1_TICKS  = 1710;

    // Default pilot pulse counts for header and data blocks
    localparam int C_PILOT_HDR   = 8063;
    localparam int C_PILOT_DATA  = 3223;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PILOT = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_SYNC2 = 3'd3,
        ST_DATA  = 3'd4
    } tape_state_t;

    // Timer reload value giving exactly 'ticks' clk cycles per pulse
    function automatic logic [15:0] reload_val(input int ticks);
        return 16'(ticks - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tape_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : tape_pulse_timer
// Description : Reloadable 16-bit down-counter. 'load' writes load_val;
//               'expire' is high while the count sits at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_pulse_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        expire
);

    logic [15:0] r_count;

    // Count down to zero and park there until the next load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != 16'd0) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign expire = (r_count == 16'd0);

endmodule
`default_nettype wire

// File: rtl/tape_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tape_pulse_gen
// Description : Cassette tape block generator: pilot tone, two sync pulses,
//               then MSB-first data bytes with two equal pulses per bit.
//               Optional trailing XOR checksum byte when the macro
//               TAPE_GEN_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_pulse_gen
    import tape_timing_pkg::*;
#(
    parameter int PILOT_TICKS = C_PILOT_TICKS,
    parameter int SYNC1_TICKS = C_SYNC1_TICKS,
    parameter int SYNC2_TICKS = C_SYNC2_TICKS,
    parameter int BIT0_TICKS  = C_BIT0_TICKS,
    parameter int BIT1_TICKS  = C_BIT1_TICKS,
    parameter int PILOT_HDR   = C_PILOT_HDR,
    parameter int PILOT_DATA  = C_PILOT_DATA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_header,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       aud,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [15:0] C_PILOT_LD = reload_val(PILOT_TICKS);
    localparam logic [15:0] C_SYNC1_LD = reload_val(SYNC1_TICKS);
    localparam logic [15:0] C_SYNC2_LD = reload_val(SYNC2_TICKS);
    localparam logic [15:0] C_BIT0_LD  = reload_val(BIT0_TICKS);
    localparam logic [15:0] C_BIT1_LD  = reload_val(BIT1_TICKS);
    localparam logic [15:0] C_HDR_CNT  = 16'(PILOT_HDR);
    localparam logic [15:0] C_DATA_CNT = 16'(PILOT_DATA);

    tape_state_t r_state, w_state_nxt;

    logic        r_aud, r_done;
    logic [15:0] r_pcnt, w_pcnt_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic        r_half, w_half_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_cur_last, w_cur_last_nxt;
    logic [7:0]  r_hold;
    logic        r_hold_full, r_hold_last, r_got_last;

    logic        w_pulse, w_boundary, w_take_hold, w_end, w_done, w_underrun;
    logic        w_expire, w_accept, w_start_ok;
    logic [15:0] w_tick_val;

`ifdef TAPE_GEN_CHECKSUM_EN
    logic [7:0]  r_cks;
    logic        r_cks_sent, w_cks_sent_nxt;
`endif

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_accept   = data_valid && data_ready;

    tape_pulse_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_pulse),
        .load_val (w_tick_val),
        .expire   (w_expire)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and pulse sequencing; w_pulse toggles aud and reloads timer
    always_comb begin
        w_state_nxt    = r_state;
        w_pulse        = 1'b0;
        w_tick_val     = C_PILOT_LD;
        w_pcnt_nxt     = r_pcnt;
        w_bit_nxt      = r_bit;
        w_half_nxt     = r_half;
        w_shift_nxt    = r_shift;
        w_cur_last_nxt = r_cur_last;
        w_boundary     = 1'b0;
        w_take_hold    = 1'b0;
        w_end          = 1'b0;
        w_done         = 1'b0;
        w_underrun     = 1'b0;
`ifdef TAPE_GEN_CHECKSUM_EN
        w_cks_sent_nxt = r_cks_sent;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_PILOT;
                    w_pulse     = 1'b1;
                    w_tick_val  = C_PILOT_LD;
                    w_pcnt_nxt  = is_header ? C_HDR_CNT : C_DATA_CNT;
`ifdef TAPE_GEN_CHECKSUM_EN
                    w_cks_sent_nxt = 1'b0;
`endif
                end
            end
            ST_PILOT: begin
                if (w_expire) begin
                    w_pulse = 1'b1;
                    if (r_pcnt <= 16'd1) begin
                        w_state_nxt = ST_SYNC1;
                        w_tick_val  = C_SYNC1_LD;
                    end else begin
                        w_pcnt_nxt  = r_pcnt - 16'd1;
                        w_tick_val  = C_PILOT_LD;
                    end
                end
            end
            ST_SYNC1: begin
                if (w_expire) begin
                    w_state_nxt = ST_SYNC2;
                    w_pulse     = 1'b1;
                    w_tick_val  = C_SYNC2_LD;
                end
            end
            ST_SYNC2: begin
                // End of sync is the boundary before the first byte
                if (w_expire) begin
                    w_boundary = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_expire) begin
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                        w_pulse    = 1'b1;
                        w_tick_val = r_shift[7] ? C_BIT1_LD : C_BIT0_LD;
                    end else if (r_bit != 3'd7) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_bit_nxt   = r_bit + 3'd1;
                        w_half_nxt  = 1'b0;
                        w_pulse     = 1'b1;
                        w_tick_val  = r_shift[6] ? C_BIT1_LD : C_BIT0_LD;
                    end else if (r_cur_last) begin
                        w_end  = 1'b1;
                        w_done = 1'b1;
`ifdef TAPE_GEN_CHECKSUM_EN
                        // Append the running XOR once before finishing
                        if (!r_cks_sent) begin
                            w_end          = 1'b0;
                            w_done         = 1'b0;
                            w_cks_sent_nxt = 1'b1;
                            w_shift_nxt    = r_cks;
                            w_bit_nxt      = 3'd0;
                            w_half_nxt     = 1'b0;
                            w_pulse        = 1'b1;
                            w_tick_val     = r_cks[7] ? C_BIT1_LD : C_BIT0_LD;
                        end
`endif
                    end else begin
                        w_boundary = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Byte boundary: pull the holding register or abort on underrun
        if (w_boundary) begin
            if (r_hold_full) begin
                w_state_nxt    = ST_DATA;
                w_take_hold    = 1'b1;
                w_shift_nxt    = r_hold;
                w_cur_last_nxt = r_hold_last;
                w_bit_nxt      = 3'd0;
                w_half_nxt     = 1'b0;
                w_pulse        = 1'b1;
                w_tick_val     = r_hold[7] ? C_BIT1_LD : C_BIT0_LD;
            end else begin
                w_underrun = 1'b1;
                w_end      = 1'b1;
            end
        end

        if (w_end) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Datapath registers: tape level, counters, shifter, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aud      <= 1'b0;
            r_done     <= 1'b0;
            r_pcnt     <= 16'd0;
            r_bit      <= 3'd0;
            r_half     <= 1'b0;
            r_shift    <= 8'd0;
            r_cur_last <= 1'b0;
`ifdef TAPE_GEN_CHECKSUM_EN
            r_cks_sent <= 1'b0;
`endif
        end else begin
            r_done     <= w_done;
            r_pcnt     <= w_pcnt_nxt;
            r_bit      <= w_bit_nxt;
            r_half     <= w_half_nxt;
            r_shift    <= w_shift_nxt;
            r_cur_last <= w_cur_last_nxt;
`ifdef TAPE_GEN_CHECKSUM_EN
            r_cks_sent <= w_cks_sent_nxt;
`endif
            if (w_end) begin
                r_aud <= 1'b0;
            end else if (w_pulse) begin
                r_aud <= ~r_aud;
            end
        end
    end

    // One-byte holding register; nothing is accepted after the last byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_got_last  <= 1'b0;
        end else if (w_end || w_start_ok) begin
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_got_last  <= 1'b0;
        end else if (w_take_hold) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
            r_hold_last <= data_last;
            r_got_last  <= data_last;
        end
    end

`ifdef TAPE_GEN_CHECKSUM_EN
    // Running XOR of every byte accepted in the current block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cks <= 8'd0;
        end else if (w_start_ok) begin
            r_cks <= 8'd0;
        end else if (w_accept && !w_end) begin
            r_cks <= r_cks ^ data_in;
        end
    end
`endif

    assign data_ready = (r_state != ST_IDLE) && !r_hold_full && !r_got_last;
    assign aud        = r_aud;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign underrun   = w_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tape_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_pulse_gen
// Description : Self-checking bench for tape_pulse_gen. Expected pulse
//               widths are queued as stimulus is driven and compared as
//               the monitor measures each completed aud pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_pulse_gen;

    localparam int PT = 4;
    localparam int S1 = 2;
    localparam int S2 = 3;
    localparam int B0 = 5;
    localparam int B1 = 10;
    localparam int PH = 6;
    localparam int PD = 3;

    logic       clk = 1'b0;
    logic       reset, start, is_header, data_valid, data_last;
    logic [7:0] data_in;
    logic       data_ready, aud, busy, done, underrun;

    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];
    int         pulses_seen = 0;
    int         done_cnt = 0;
    int         und_cnt = 0;
    int         cnt = 0;
    bit         mon_en = 1'b0;
    logic       prev_aud = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] cks;

    always #5 clk = ~clk;

    tape_pulse_gen #(
        .PILOT_TICKS (PT),
        .SYNC1_TICKS (S1),
        .SYNC2_TICKS (S2),
        .BIT0_TICKS  (B0),
        .BIT1_TICKS  (B1),
        .PILOT_HDR   (PH),
        .PILOT_DATA  (PD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_header  (is_header),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .aud        (aud),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    // Measure each aud pulse (ended by a toggle or busy falling) and score it
    always @(negedge clk) begin : mon
        int exp_w;
        if (prev_busy === 1'b1 && (aud !== prev_aud || busy !== 1'b1)) begin
            pulses_seen++;
            if (mon_en) begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
                checks++;
                assert (cnt === exp_w) else begin
                    errors++;
                    $error("FAIL pulse_width got %0d exp %0d", cnt, exp_w);
                end
            end
            cnt = 1;
        end else if (prev_busy !== 1'b1) begin
            cnt = 1;
        end else begin
            cnt++;
        end
        if (done === 1'b1)     done_cnt++;
        if (underrun === 1'b1) und_cnt++;
        prev_aud  = aud;
        prev_busy = busy;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(b[i] ? B1 : B0);
            exp_q.push_back(b[i] ? B1 : B0);
        end
    endtask

    task automatic start_block(input logic hdr);
        cks       = 8'h00;
        start     = 1'b1;
        is_header = hdr;
        for (int i = 0; i < (hdr ? PH : PD); i++) exp_q.push_back(PT);
        exp_q.push_back(S1);
        exp_q.push_back(S2);
        step();
        start     = 1'b0;
        is_header = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input logic last);
        int n = 0;
        while (data_ready !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        chk("feed_ready_timeout", 32'(n < 2000), 1);
        data_in    = b;
        data_last  = last;
        data_valid = 1'b1;
        push_byte(b);
        cks = cks ^ b;
        step();
        data_valid = 1'b0;
        data_last  = 1'b0;
`ifdef TAPE_GEN_CHECKSUM_EN
        if (last) push_byte(cks);
`endif
    endtask

    task automatic wait_end(input string tag, input int exp_done, input int exp_und);
        int n  = 0;
        int d0 = done_cnt;
        int u0 = und_cnt;
        while (busy === 1'b1 && n < 5000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 5000), 1);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_aud"}, 32'(aud), 0);
        chk({tag, "_ready"}, 32'(data_ready), 0);
        step();
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'(exp_done));
        chk({tag, "_underrun_count"}, 32'(und_cnt - u0), 32'(exp_und));
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin : main
        int n;
        int ps0;
        reset      = 1'b1;
        start      = 1'b0;
        is_header  = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        data_last  = 1'b0;
        cks        = 8'h00;
        repeat (3) step();
        chk("rst_aud", 32'(aud), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_ready", 32'(data_ready), 0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;

        // Header block, single byte 0x80
        start_block(1'b1);
        chk("start_busy", 32'(busy), 1);
        chk("start_aud", 32'(aud), 1);
        feed(8'h80, 1'b1);
        wait_end("hdr80", 1, 0);

        // Data block, two bytes
        start_block(1'b0);
        feed(8'hA5, 1'b0);
        feed(8'h3C, 1'b1);
        wait_end("a5_3c", 1, 0);

        // Second byte withheld
        start_block(1'b0);
        feed(8'h5A, 1'b0);
        wait_end("underrun", 0, 1);
        chk("underrun_busy_after", 32'(busy), 0);

        // Reset during SYNC2 aborts, then a fresh block replays full pilot
        ps0 = pulses_seen;
        start_block(1'b0);
        feed(8'hC3, 1'b1);
        n = 0;
        while (pulses_seen < ps0 + PD + 1 && n < 2000) begin
            step();
            n++;
        end
        chk("sync2_reach_timeout", 32'(n < 2000), 1);
        mon_en = 1'b0;
        reset  = 1'b1;
        step();
        chk("abort_aud", 32'(aud), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_underrun", 32'(underrun), 0);
        chk("abort_ready", 32'(data_ready), 0);
        reset = 1'b0;
        exp_q.delete();
        step();
        mon_en = 1'b1;
        start_block(1'b1);
        feed(8'h00, 1'b1);
        wait_end("after_abort", 1, 0);

        // Start pulsed during pilot is ignored
        start_block(1'b0);
        feed(8'hF0, 1'b1);
        start     = 1'b1;
        is_header = 1'b1;
        step();
        start     = 1'b0;
        is_header = 1'b0;
        wait_end("restart_ignored", 1, 0);

        // Checksum case: 0x12 ^ 0x34 = 0x26 appended when enabled
        start_block(1'b0);
        feed(8'h12, 1'b0);
        feed(8'h34, 1'b1);
        wait_end("cks", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
